regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Sequences all access to the 32×32 integer register file (the `RegFile` instance). It shares the write port between pipeline writeback and a debug requester, and steals the rs1 read port for debug reads while the core is halted. It sits between the writeback stage, the debug module and `RegFile`. It optionally runs a zero-clear sweep of x1–x31 after reset.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, register count; x0 is hardwired zero
- `AW`, 5, register address width (log2 NREG)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `halted`  in  1  core halted; debug access permitted
- `wb_en`, `wb_rd`, `wb_data`  in  1/AW/XLEN  pipeline writeback
- `pipe_rs1`, `pipe_rs2`  in  AW  pipeline read addresses
- `pipe_rs1_out`, `pipe_rs2_out`  out  XLEN  pipeline read data
- `stall`  out  1  pipeline must hold (clear sweep active)
- `dbg_req_valid`, `dbg_req_ready`  in/out  1  debug request handshake
- `dbg_req_write`  in  1  1 = write, 0 = read
- `dbg_req_addr`, `dbg_req_wdata`  in  AW/XLEN  debug address and data
- `dbg_rsp_valid`, `dbg_rsp_ready`  out/in  1  debug response handshake
- `dbg_rsp_data`  out  XLEN  read data; 0 for writes
- `io_rs1`, `io_rs2`, `io_rd`  out  AW  to RegFile
- `io_wdata`  out  XLEN  to RegFile
- `io_Reg_Write`  out  1  to RegFile
- `io_rs1_out`, `io_rs2_out`  in  XLEN  from RegFile

## Operation
- FSM states: CLEAR (only with the macro), IDLE, RSP.
- `wb_busy` = `wb_en` && `wb_rd` != 0.
- **Write-port ownership:**
  - Writeback has priority and always owns the port when `wb_busy`.
  - Writeback is ignored in CLEAR; the pipeline is stalled then.
- **Debug ready:** `dbg_req_ready` = (state == IDLE) && `halted` && !`wb_busy`. Combinational; never depends on `dbg_req_valid`.
- **Accept:** a request is accepted when valid && ready. State goes to RSP and `dbg_rsp_valid` is set at the next edge.
- **Accepted write:**
  - Drives `io_rd`/`io_wdata` with `io_Reg_Write` = 1 in the accept cycle.
  - If the address is 0, `io_Reg_Write` stays 0 (suppressed), but a response is still issued.
  - `dbg_rsp_data` = 0.
- **Accepted read:**
  - `io_rs1` = `dbg_req_addr` in the accept cycle.
  - `io_rs1_out` is captured into `dbg_rsp_data`.
  - Address 0 returns 0.
- **RSP:** holds data and valid until `dbg_rsp_ready`, then returns to IDLE. No new request is accepted in RSP.
- **Pipeline read path:** when not stolen, `io_rs1`/`io_rs2` = `pipe_rs1`/`pipe_rs2`, and `pipe_rsN_out` = `io_rsN_out`.
- **Debug read while halted:** when a debug read steals rs1, `pipe_rs1_out` is undefined. The pipeline does not use it while `halted`.
- **Idle write port:** when the port is unused, `io_Reg_Write` = 0 and `io_rd`/`io_wdata` = 0.

## Timing
- **Reset values** (async, while `reset` = 0):
  - `dbg_rsp_valid` = 0, `dbg_rsp_data` = 0.
  - State = CLEAR with the macro, IDLE without it.
  - `stall` = 1 with the macro, 0 without it.
  - Sweep counter = 1.
- **Write latency:** the RegFile update lands at the accept-cycle edge. The response is valid one cycle after accept.
- **Read latency:** response valid one cycle after accept, with data from the pre-edge contents.
- **Back-to-back:** minimum 2 cycles per debug transaction (accept, then response with `dbg_rsp_ready` = 1). The next accept is possible in the cycle after the response handshake.
- **`halted` drop:** if `halted` falls while in RSP, the response still completes. Only new accepts are blocked.
- **Reset mid-transaction:** the response is discarded and no partial write occurs after reset assertion.

## Configuration
- Macro `RF_CLEAR_ON_RESET_EN`.
- **Defined:**
  - After reset release, CLEAR writes 0 to x1..x31, one per cycle (31 cycles), with `io_Reg_Write` = 1.
  - The counter wraps from 31 to IDLE.
  - `stall` = 1 and `dbg_req_ready` = 0 throughout the sweep.
  - `stall` falls in the cycle IDLE is entered.
- **Undefined:** no CLEAR state, `stall` is tied 0, and RegFile contents after reset are left to preload.

## Test plan
- Halted, debug write x5 = 0xDEADBEEF, then debug read x5 -> `io_Reg_Write` pulses 1 cycle with `io_rd` = 5; read response `dbg_rsp_data` = 0xDEADBEEF, one cycle after accept.
- Debug write to x0 with 0x1234, then read x0 -> `io_Reg_Write` stays 0; both responses valid; read data = 0.
- Halted, `dbg_req_valid` = 1 for a write while `wb_en` = 1, `wb_rd` = 7, `wb_data` = 0x11 -> `dbg_req_ready` = 0 that cycle; writeback x7 = 0x11 commits; debug write is accepted the next cycle.
- `halted` = 0 with `dbg_req_valid` held -> `dbg_req_ready` stays 0 for 10 cycles; pipeline reads pass through unchanged.
- Response held with `dbg_rsp_ready` = 0 for 5 cycles -> `dbg_rsp_valid`/data stable, no new accept; `reset` asserted in cycle 3 -> `dbg_rsp_valid` = 0 immediately.
- With `RF_CLEAR_ON_RESET_EN`, RegFile preloaded nonzero -> 31 write cycles to x1..x31 with data 0, `stall` high for exactly 31 cycles; a debug read of x31 afterwards returns 0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares RegFile write/rs1 ports between writeback and a debug requester.
// Define RF_CLEAR_ON_RESET_EN to zero x1..x31 in a stalled sweep after reset.
module regfile_access_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halted,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   pipe_rs1,
  input  logic [AW-1:0]   pipe_rs2,
  output logic [XLEN-1:0] pipe_rs1_out,
  output logic [XLEN-1:0] pipe_rs2_out,
  output logic            stall,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_req_write,
  input  logic [AW-1:0]   dbg_req_addr,
  input  logic [XLEN-1:0] dbg_req_wdata,
  output logic            dbg_rsp_valid,
  input  logic            dbg_rsp_ready,
  output logic [XLEN-1:0] dbg_rsp_data,
  output logic [AW-1:0]   io_rs1,
  output logic [AW-1:0]   io_rs2,
  output logic [AW-1:0]   io_rd,
  output logic [XLEN-1:0] io_wdata,
  output logic            io_Reg_Write,
  input  logic [XLEN-1:0] io_rs1_out,
  input  logic [XLEN-1:0] io_rs2_out
);
`ifdef RF_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {CLEAR, IDLE, RSP} state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, RSP} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            wb_busy, accept, dbg_wr, addr_live;
  // Addresses that are x0 or beyond NREG read as zero and never write.
  assign addr_live = dbg_req_addr != '0 && 32'(dbg_req_addr) < NREG;
  always_comb begin
    wb_busy       = wb_en && wb_rd != '0;
    dbg_req_ready = state_q == IDLE && halted && !wb_busy && reset;
    accept        = dbg_req_valid && dbg_req_ready;
    dbg_wr        = accept && dbg_req_write && addr_live;
    io_rs1        = accept && !dbg_req_write ? dbg_req_addr : pipe_rs1;
    io_rs2        = pipe_rs2;
    pipe_rs1_out  = io_rs1_out;
    pipe_rs2_out  = io_rs2_out;
    io_Reg_Write  = wb_busy || dbg_wr;
    io_rd         = wb_busy ? wb_rd : dbg_wr ? dbg_req_addr : '0;
    io_wdata      = wb_busy ? wb_data : dbg_wr ? dbg_req_wdata : '0;
    stall         = 1'b0;
    cnt_d         = cnt_q;
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    if (accept) begin
      state_d     = RSP;
      rsp_valid_d = 1'b1;
      rsp_data_d  = dbg_req_write || !addr_live ? '0 : io_rs1_out;
    end
    if (state_q == RSP && dbg_rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
`ifdef RF_CLEAR_ON_RESET_EN
    // Sweep owns the write port outright; writeback is ignored while stalled.
    if (state_q == CLEAR) begin
      stall        = 1'b1;
      io_Reg_Write = 1'b1;
      io_rd        = cnt_q;
      io_wdata     = '0;
      cnt_d        = cnt_q + AW'(1);
      state_d      = cnt_q == AW'(NREG - 1) ? IDLE : CLEAR;
    end
`endif
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= AW'(1);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed table-driven bench with a behavioural RegFile model.
module tb_regfile_access_ctrl;
  logic clock = 1'b0, reset = 1'b0;
  logic halted = 1'b0, wb_en = 1'b0, dbg_req_valid = 1'b0, dbg_req_write = 1'b0, dbg_rsp_ready = 1'b0;
  logic [4:0] wb_rd = '0, pipe_rs1 = '0, pipe_rs2 = '0, dbg_req_addr = '0;
  logic [31:0] wb_data = '0, dbg_req_wdata = '0;
  logic [31:0] pipe_rs1_out, pipe_rs2_out, dbg_rsp_data, io_wdata, io_rs1_out, io_rs2_out;
  logic [4:0] io_rs1, io_rs2, io_rd;
  logic stall, dbg_req_ready, dbg_rsp_valid, io_Reg_Write;
  logic load = 1'b0;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  regfile_access_ctrl dut (
    .clock(clock), .reset(reset), .halted(halted),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pipe_rs1(pipe_rs1), .pipe_rs2(pipe_rs2),
    .pipe_rs1_out(pipe_rs1_out), .pipe_rs2_out(pipe_rs2_out), .stall(stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_data(dbg_rsp_data),
    .io_rs1(io_rs1), .io_rs2(io_rs2), .io_rd(io_rd), .io_wdata(io_wdata),
    .io_Reg_Write(io_Reg_Write), .io_rs1_out(io_rs1_out), .io_rs2_out(io_rs2_out)
  );

  // RegFile model; x0 deliberately holds garbage so the DUT must zero it itself.
  always @(posedge clock)
    if (load) for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD : 32'h100 + i;
    else if (io_Reg_Write) mem[io_rd] <= io_wdata;
  assign io_rs1_out = mem[io_rs1];
  assign io_rs2_out = mem[io_rs2];

  typedef struct {
    logic h, we, v, w;
    logic [4:0] wrd, rs1, rs2, a;
    logic [31:0] wd, dd;
    logic e_rdy, e_wr;
    logic [4:0] e_rd, e_rs1;
    logic [31:0] e_wd, e_p1, e_p2, e_rsp;
  } vec_t;
  vec_t v [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    halted = t.h; wb_en = t.we; wb_rd = t.wrd; wb_data = t.wd;
    pipe_rs1 = t.rs1; pipe_rs2 = t.rs2;
    dbg_req_valid = t.v; dbg_req_write = t.w; dbg_req_addr = t.a; dbg_req_wdata = t.dd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (stall && n < 100) begin n++; tick(); end
    chk("sweep_bounded", 32'(n < 100), 32'd1);
`ifdef RF_CLEAR_ON_RESET_EN
    chk("sweep_len", n, 32'd31);
`else
    chk("no_sweep", n, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{1,0,1,1, 0,3,4,5, 0,32'hDEADBEEF, 1,1,5,3,32'hDEADBEEF,32'h103,32'h104,0};
    v[1]  = '{1,0,1,0, 0,3,4,5, 0,0,            1,0,0,5,0,0,32'h104,32'hDEADBEEF};
    v[2]  = '{1,0,1,1, 0,3,4,0, 0,32'h1234,     1,0,0,3,0,32'h103,32'h104,0};
    v[3]  = '{1,0,1,0, 0,3,4,0, 0,0,            1,0,0,0,0,0,32'h104,0};
    v[4]  = '{1,1,1,1, 7,3,4,9, 32'h11,32'h55,  0,1,7,3,32'h11,32'h103,32'h104,0};
    v[5]  = '{1,0,1,1, 0,3,4,9, 0,32'h55,       1,1,9,3,32'h55,32'h103,32'h104,0};
    v[6]  = '{1,0,1,0, 0,3,4,7, 0,0,            1,0,0,7,0,0,32'h104,32'h11};
    v[7]  = '{1,0,1,0, 0,3,4,9, 0,0,            1,0,0,9,0,0,32'h104,32'h55};
    v[8]  = '{0,0,1,0, 0,6,7,2, 0,0,            0,0,0,6,0,32'h106,32'h11,0};
    v[9]  = '{1,1,1,0, 0,3,4,8, 32'hFFFF,0,     1,0,0,8,0,0,32'h104,32'h108};
    v[10] = '{0,1,0,0, 3,3,4,0, 32'h33,0,       0,1,3,3,32'h33,32'h103,32'h104,0};
    v[11] = '{1,0,1,0, 0,3,4,3, 0,0,            1,0,0,3,0,0,32'h104,32'h33};

    load = 1'b1;
    repeat (2) tick();
    chk("rst_rsp_valid", 32'(dbg_rsp_valid), 0);
    chk("rst_rsp_data", dbg_rsp_data, 0);
`ifdef RF_CLEAR_ON_RESET_EN
    chk("rst_stall", 32'(stall), 1);
`else
    chk("rst_stall", 32'(stall), 0);
`endif
    load = 1'b0;
    reset = 1'b1;
    wait_sweep();
`ifdef RF_CLEAR_ON_RESET_EN
    chk("sweep_x1", mem[1], 0);
    chk("sweep_x31", mem[31], 0);
    load = 1'b1;
    tick();
    load = 1'b0;
`endif

    for (int i = 0; i < 12; i++) begin
      logic acc;
      drive(v[i]);
      acc = v[i].v && v[i].e_rdy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(dbg_req_ready), 32'(v[i].e_rdy));
      chk($sformatf("v%0d_we", i), 32'(io_Reg_Write), 32'(v[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(io_rd), 32'(v[i].e_rd));
      chk($sformatf("v%0d_wdata", i), io_wdata, v[i].e_wd);
      chk($sformatf("v%0d_io_rs1", i), 32'(io_rs1), 32'(v[i].e_rs1));
      chk($sformatf("v%0d_p2", i), pipe_rs2_out, v[i].e_p2);
      if (!(acc && !v[i].w)) chk($sformatf("v%0d_p1", i), pipe_rs1_out, v[i].e_p1);
      tick();
      dbg_req_valid = 1'b0;
      wb_en = 1'b0;
      if (acc) begin
        chk($sformatf("v%0d_rsp_valid", i), 32'(dbg_rsp_valid), 1);
        chk($sformatf("v%0d_rsp_data", i), dbg_rsp_data, v[i].e_rsp);
        chk($sformatf("v%0d_rsp_noready", i), 32'(dbg_req_ready), 0);
        dbg_rsp_ready = 1'b1;
        tick();
        dbg_rsp_ready = 1'b0;
      end
      chk($sformatf("v%0d_rsp_idle", i), 32'(dbg_rsp_valid), 0);
    end

    halted = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr = 5'd2;
    for (int k = 0; k < 10; k++) begin
      pipe_rs1 = 5'(10 + k);
      pipe_rs2 = 5'(20 + k);
      #1;
      chk($sformatf("nohalt%0d_ready", k), 32'(dbg_req_ready), 0);
      chk($sformatf("nohalt%0d_p1", k), pipe_rs1_out, 32'h10A + k);
      chk($sformatf("nohalt%0d_p2", k), pipe_rs2_out, 32'h114 + k);
      tick();
    end
    chk("nohalt_rsp_valid", 32'(dbg_rsp_valid), 0);

    halted = 1'b1;
    dbg_req_addr = 5'd5;
    tick();
    dbg_req_write = 1'b1;
    dbg_req_addr = 5'd6;
    dbg_req_wdata = 32'h77;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_valid", k), 32'(dbg_rsp_valid), 1);
      chk($sformatf("hold%0d_data", k), dbg_rsp_data, 32'hDEADBEEF);
      chk($sformatf("hold%0d_ready", k), 32'(dbg_req_ready), 0);
      chk($sformatf("hold%0d_we", k), 32'(io_Reg_Write), 0);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(dbg_rsp_valid), 0);
    chk("midrst_rsp_data", dbg_rsp_data, 0);
    chk("midrst_ready", 32'(dbg_req_ready), 0);
`ifndef RF_CLEAR_ON_RESET_EN
    chk("midrst_we", 32'(io_Reg_Write), 0);
`endif
    tick();
    tick();
    dbg_req_valid = 1'b0;
    reset = 1'b1;
    wait_sweep();
`ifndef RF_CLEAR_ON_RESET_EN
    chk("midrst_no_write", mem[6], 32'h106);
`endif
    #1;
    chk("post_rst_ready", 32'(dbg_req_ready), 1);
    chk("post_rst_rsp_valid", 32'(dbg_rsp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
